// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//
// Shared definitions for the registered one-hot decoder slice.
//   state_e     : control state of decoder_seq (IDLE, DIRECT, SCAN)
//   N_DEFAULT   : default select width used by the slice
//   OUT_W       : one-hot width for the default select width (1 << N_DEFAULT)
//   MAX_N       : widest select width the onehot_of helper supports
//   onehot_of() : returns the one-hot image of a code for an n-bit select,
//                 right-justified in a MAX_OUT_W-bit vector
// ---------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam int N_DEFAULT = 3;
    localparam int OUT_W     = 1 << N_DEFAULT;

    // Instances must keep N <= MAX_N; wider selects would need a bigger
    // helper vector.
    localparam int MAX_N     = 8;
    localparam int MAX_OUT_W = 1 << MAX_N;

    // Callers narrow the result to their own 2^n width with a size cast, so
    // the upper bits are never used for n < MAX_N.
    function automatic logic [MAX_OUT_W-1:0] onehot_of(input int unsigned code,
                                                       input int unsigned n);
        logic [MAX_OUT_W-1:0] vec;
        vec = '0;
        if ((n <= MAX_N) && (code < (32'd1 << n))) begin
            vec[code[MAX_N-1:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// ---------------------------------------------------------------------------
// decoder_onehot
//
// Purely combinational N-to-2^N decoder with selectable output polarity.
//   code   in  N    code to decode (every value maps to exactly one line)
//   onehot out 2^N  decoded line; active-high, or active-low when ACT_LOW=1
// ---------------------------------------------------------------------------
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int N       = 3,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic [N-1:0]      code,
    output logic [(1<<N)-1:0] onehot
);

    localparam int W = 1 << N;

    // Build the active-high one-hot from the shared helper, then invert the
    // whole vector when the consumer wants active-low lines.
    always_comb begin
        onehot = W'(onehot_of(32'(code), N));
        if (ACT_LOW) begin
            onehot = ~onehot;
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
//
// Registered N-to-2^N one-hot decoder with valid/ready handshakes, a single
// entry output register with backpressure, and an autonomous scan mode that
// walks every code with a programmable dwell.
//
// Ports:
//   clk        in  1    rising-edge clock
//   rst        in  1    synchronous active-high reset
//   en         in  1    block enable (0 parks the control in IDLE)
//   mode       in  1    0 = direct decode of in_sel, 1 = scan
//   in_valid   in  1    in_sel carries a code
//   in_ready   out 1    block accepts in_sel this cycle
//   in_sel     in  N    code to decode
//   out_valid  out 1    out_onehot/out_code hold a decoded result
//   out_ready  in  1    consumer takes the result
//   out_onehot out 2^N  decoded one-hot, polarity set by ACT_LOW
//   out_code   out N    code that produced out_onehot
//   scan_wrap  out 1    one-cycle pulse when a scan load presents code 2^N-1
// ---------------------------------------------------------------------------
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL   = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [(1<<N)-1:0] out_onehot,
    output logic [N-1:0]      out_code,
    output logic              scan_wrap
);

    localparam int W    = 1 << N;
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [W-1:0]    INACTIVE   = ACT_LOW ? {W{1'b1}} : {W{1'b0}};

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_code_q, out_code_d;
    logic [W-1:0]    out_onehot_q, out_onehot_d;
    logic            scan_wrap_q, scan_wrap_d;
    logic [N-1:0]    scan_cnt_q, scan_cnt_d;
    logic [DW_W-1:0] dwell_q, dwell_d;

    logic            slot_free;
    logic            direct_ready;
    logic            direct_load;
    logic            scan_load;
    logic [N-1:0]    load_code;
    logic [W-1:0]    load_onehot;

    // Handshake view of the output register. The slot is free when it is
    // empty or being drained this cycle, which is what lets direct mode
    // sustain one transfer per clock. Only one source can load per cycle
    // because direct and scan loads belong to different states.
    always_comb begin
        slot_free    = !out_valid_q || out_ready;
        direct_ready = (state_q == DIRECT) && slot_free;
        direct_load  = direct_ready && in_valid;
        scan_load    = (state_q == SCAN) && (dwell_q == DWELL_LAST) && slot_free;
        load_code    = direct_load ? in_sel : scan_cnt_q;
    end

    assign in_ready = direct_ready;

    decoder_onehot #(
        .N       (N),
        .ACT_LOW (ACT_LOW)
    ) u_onehot (
        .code   (load_code),
        .onehot (load_onehot)
    );

    // Next-state logic for the control state, scan counters and the output
    // register. The state only moves while the slot is free, so en/mode
    // changes wait until a pending result has been taken. The dwell counter
    // parks at its last value while the consumer stalls, so the waiting scan
    // load fires on the first free cycle and no code is skipped.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        scan_cnt_d   = scan_cnt_q;
        out_valid_d  = out_valid_q;
        out_code_d   = out_code_q;
        out_onehot_d = out_onehot_q;
        scan_wrap_d  = 1'b0;

        if (slot_free) begin
            if (!en) begin
                state_d = IDLE;
            end else if (mode) begin
                state_d = SCAN;
            end else begin
                state_d = DIRECT;
            end
        end

        if (state_q == SCAN) begin
            if (dwell_q != DWELL_LAST) begin
                dwell_d = dwell_q + DW_W'(1);
            end else if (slot_free) begin
                dwell_d    = '0;
                scan_cnt_d = scan_cnt_q + N'(1);
            end
        end

        // A fresh entry into scan always restarts the walk from code 0.
        if ((state_d == SCAN) && (state_q != SCAN)) begin
            scan_cnt_d = '0;
            dwell_d    = '0;
        end

        if (direct_load || scan_load) begin
            out_valid_d  = 1'b1;
            out_code_d   = load_code;
            out_onehot_d = load_onehot;
            scan_wrap_d  = scan_load && (scan_cnt_q == {N{1'b1}});
        end else if (out_valid_q && out_ready) begin
            // out_code deliberately keeps the last delivered code.
            out_valid_d  = 1'b0;
            out_onehot_d = INACTIVE;
        end
    end

    // All state registers. Reset wins over everything, including a result
    // still waiting for out_ready, which is simply discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            out_onehot_q <= INACTIVE;
            scan_wrap_q  <= 1'b0;
            scan_cnt_q   <= '0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            out_onehot_q <= out_onehot_d;
            scan_wrap_q  <= scan_wrap_d;
            scan_cnt_q   <= scan_cnt_d;
            dwell_q      <= dwell_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_onehot = out_onehot_q;
    assign scan_wrap  = scan_wrap_q;

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 3-to-8 combinational decoder.
- Adds valid/ready handshaking on input and output, a single-entry output register with backpressure, selectable output polarity, and an autonomous scan mode.
- Scan mode walks every code 0..2^N-1 with a programmable dwell, for lamp/LED and board bring-up.
- Sits between a code source (CPU register or counter) and one-hot consumers: display digit enables, chip selects.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL, 4, cycles between successive scan-mode loads (>=1).
- ACT_LOW, 0, 1 = one-hot output active-low (inactive lines driven 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  in_sel is valid.
- in_ready  out  1  block accepts in_sel this cycle.
- in_sel  in  N  code to decode.
- out_valid  out  1  out_onehot/out_code hold a decoded result.
- out_ready  in  1  consumer accepts the result.
- out_onehot  out  2^N  decoded one-hot (polarity per ACT_LOW).
- out_code  out  N  code that produced out_onehot.
- scan_wrap  out  1  one-cycle pulse when scan loads code 2^N-1.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst); all state updates on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, out_code=0, out_onehot=all inactive (0s; all 1s if ACT_LOW), scan_wrap=0, scan counter=0, dwell counter=0. rst has priority over every other event, including a pending output mid-handshake; the pending result is discarded.
- Slot free is defined as slot_free = !out_valid || out_ready.
- FSM states: IDLE, DIRECT, SCAN. Transitions are evaluated each cycle, only when slot_free:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
  - When not slot_free, state holds, so mode/en changes never corrupt a pending output.
- Entering SCAN from any other state clears the scan counter and dwell counter to 0.
- in_ready = (state==DIRECT) && slot_free; combinational, no dependence on in_valid.
- DIRECT: on in_valid && in_ready, next cycle out_valid=1, out_code=in_sel, out_onehot bit[in_sel] active, all other bits inactive. Latency is 1 cycle. Back-to-back transfers at 1 per cycle are sustained while out_ready=1.
- Output hold: while out_valid && !out_ready, out_onehot and out_code stay stable.
- Output release: when out_valid && out_ready and no new load occurs in the same cycle, out_valid->0 and out_onehot->all inactive. out_code keeps its last value.
- Simultaneous drain and load (out_ready=1 and a new transfer) gives back-to-back output; out_valid stays 1.
- SCAN:
  - in_ready=0.
  - Dwell counter increments each cycle up to DWELL-1.
  - When dwell==DWELL-1 and slot_free: load code=scan counter, dwell->0, scan counter += 1 mod 2^N (wraps 2^N-1 -> 0).
  - When dwell==DWELL-1 and !slot_free: dwell stalls at DWELL-1 and the load waits.
  - scan_wrap=1 for exactly the cycle in which out_code becomes 2^N-1 via a scan load. It is registered alongside the output.
- IDLE: no loads and in_ready=0. A pending output still drains normally.
- Width rules: in_sel is fully decoded; every N-bit value maps to exactly one line, with no out-of-range case. Scan counter is N bits and wraps naturally.

Decomposition:
- Package decoder_pkg:
  - state enum {IDLE, DIRECT, SCAN}.
  - Function onehot_of(code, N) returning the 2^N-bit vector.
  - Localparam OUT_W = 1<<N.
- One sub-module, decoder_onehot: purely combinational N-to-2^N decode with an ACT_LOW polarity parameter, instantiated once and feeding the output register.
- The FSM, dwell counter, scan counter and output register stay in decoder_seq.

Test Plan:
- Reset then direct mode (N=3, en=1, mode=0, out_ready=1): in_sel 0..7, one per cycle with in_valid=1 -> each next cycle out_onehot=0x01,0x02,...,0x80, out_code matches, out_valid continuous.
- Backpressure: load in_sel=5, hold out_ready=0 for 3 cycles -> out_onehot=0x20 stable, in_ready=0. Raise out_ready with in_valid/in_sel=2 -> next cycle out_onehot=0x04, no bubble.
- Scan mode (DWELL=4, out_ready=1): out_code sequence 0,1,...,7,0 with loads every 4 cycles. scan_wrap high only in the cycle out_code=7.
- Scan stall: out_ready=0 during scan for 10 cycles -> out_code frozen, counter not advanced. Release -> next code follows with no code skipped.
- Mode switch with pending output: out_valid=1, out_ready=0, set mode=1 -> state stays DIRECT until drain, then scan starts at code 0.
- ACT_LOW=1, rst asserted mid-scan: during reset out_onehot=0xFF, out_valid=0. After decoding in_sel=3 -> out_onehot=0xF7.
